// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID stage operands
  logic             id_valid;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             two_src;
  // EXE / MEM destinations
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  // data-memory handshake and branch resolution
  logic             mem_req;
  logic             mem_ready;
  logic             branch_taken;
  // pipeline control
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             freeze_back;
  // status
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // pipeline side: drives observations, consumes control
  modport master (
    output id_valid, src1, src2, two_src,
    output exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
    output mem_req, mem_ready, branch_taken,
    input  freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back,
    input  mem_timeout, stall_cnt, flush_cnt
  );

  // controller side
  modport slave (
    input  id_valid, src1, src2, two_src,
    input  exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
    input  mem_req, mem_ready, branch_taken,
    output freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back,
    output mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int FWD_EN  = 1,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int              WC_W      = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX  = WC_W'(TIMEOUT);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);
  localparam logic            FWD       = (FWD_EN != 0);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic exe_hit;
  logic mem_hit;
  logic raw;
  logic mem_wait;
  logic do_flush;
  logic do_stall;
  logic do_wait;

  // RAW detection and priority resolution: memory wait > branch flush > RAW stall
  always_comb begin
    exe_hit  = (hz.src1 == hz.exe_dest) | (hz.two_src & (hz.src2 == hz.exe_dest));
    mem_hit  = (hz.src1 == hz.mem_dest) | (hz.two_src & (hz.src2 == hz.mem_dest));
    raw      = hz.id_valid &
               ((exe_hit & hz.exe_wb_en & (hz.exe_mem_r_en | ~FWD)) |
                (~FWD & mem_hit & hz.mem_wb_en));
    mem_wait = (state_q == MEMWAIT) | (hz.mem_req & ~hz.mem_ready);
    // all control outputs are forced quiet while reset is held
    do_wait  = ~rst & mem_wait;
    do_flush = ~rst & ~mem_wait & hz.branch_taken;
    do_stall = ~rst & ~mem_wait & ~hz.branch_taken & raw;
  end

  assign hz.freeze_pc    = do_wait | do_stall;
  assign hz.freeze_if_id = do_wait | do_stall;
  assign hz.freeze_back  = do_wait;
  assign hz.flush_if_id  = do_flush;
  assign hz.flush_id_ex  = do_flush | do_stall;
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

  // next-state: memory-wait FSM, wait timer, sticky timeout and event counters
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;

    case (state_q)
      RUN: begin
        // a request completed in the same cycle never leaves RUN
        if (hz.mem_req && !hz.mem_ready) begin
          state_d = MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (hz.mem_ready) begin
          state_d = RUN;
        end
        wait_cnt_d = (wait_cnt_q != WAIT_MAX) ? wait_cnt_q + 1'b1 : wait_cnt_q;
        // the flag only reports; the freeze is held until the memory answers
        if ((wait_cnt_q == WAIT_LAST) && !hz.mem_ready) begin
          mem_timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (do_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (do_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // state registers; reset abandons any in-flight memory access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

endmodule
